// File: rtl/deco_lectura_registros.sv
// Read-side register decoder for the PicoBlaze in_port bus.
// Anchor reads latch coherent shadows; status read clears the sticky timer flag.
module deco_lectura_registros #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              read_strobe,
  input  logic [ADDR_W-1:0] port_id,
  input  logic [DATA_W-1:0] seg_hora,
  input  logic [DATA_W-1:0] min_hora,
  input  logic [DATA_W-1:0] hora_hora,
  input  logic [DATA_W-1:0] dia_fecha,
  input  logic [DATA_W-1:0] mes_fecha,
  input  logic [DATA_W-1:0] jahr_fecha,
  input  logic [DATA_W-1:0] seg_timer,
  input  logic [DATA_W-1:0] min_timer,
  input  logic [DATA_W-1:0] hora_timer,
  input  logic              timer_fin,
  output logic [DATA_W-1:0] in_port,
  output logic              irq_timer
);

  localparam logic [ADDR_W-1:0] P_SEG_H  = ADDR_W'('h03);
  localparam logic [ADDR_W-1:0] P_MIN_H  = ADDR_W'('h04);
  localparam logic [ADDR_W-1:0] P_HORA_H = ADDR_W'('h05);
  localparam logic [ADDR_W-1:0] P_DIA_F  = ADDR_W'('h06);
  localparam logic [ADDR_W-1:0] P_MES_F  = ADDR_W'('h07);
  localparam logic [ADDR_W-1:0] P_JAHR_F = ADDR_W'('h08);
  localparam logic [ADDR_W-1:0] P_SEG_T  = ADDR_W'('h0A);
  localparam logic [ADDR_W-1:0] P_MIN_T  = ADDR_W'('h0B);
  localparam logic [ADDR_W-1:0] P_HORA_T = ADDR_W'('h0C);
  localparam logic [ADDR_W-1:0] P_STAT   = ADDR_W'('h0D);

  logic [DATA_W-1:0] in_port_q, in_port_d;
  logic [DATA_W-1:0] min_h_q, min_h_d;
  logic [DATA_W-1:0] hora_h_q, hora_h_d;
  logic [DATA_W-1:0] mes_f_q, mes_f_d;
  logic [DATA_W-1:0] jahr_f_q, jahr_f_d;
  logic [DATA_W-1:0] min_t_q, min_t_d;
  logic [DATA_W-1:0] hora_t_q, hora_t_d;
  logic              flag_q, flag_d;

  logic cap_h, cap_f, cap_t, clr;

  always_comb begin
    cap_h = read_strobe && (port_id == P_SEG_H);
    cap_f = read_strobe && (port_id == P_DIA_F);
    cap_t = read_strobe && (port_id == P_SEG_T);
    clr   = read_strobe && (port_id == P_STAT);

    min_h_d  = cap_h ? min_hora   : min_h_q;
    hora_h_d = cap_h ? hora_hora  : hora_h_q;
    mes_f_d  = cap_f ? mes_fecha  : mes_f_q;
    jahr_f_d = cap_f ? jahr_fecha : jahr_f_q;
    min_t_d  = cap_t ? min_timer  : min_t_q;
    hora_t_d = cap_t ? hora_timer : hora_t_q;

    // A new expiry beats a clearing read in the same cycle
    flag_d = flag_q;
    if (clr)       flag_d = 1'b0;
    if (timer_fin) flag_d = 1'b1;

    in_port_d = '0;
    case (port_id)
      P_SEG_H:  in_port_d = seg_hora;
      P_MIN_H:  in_port_d = min_h_q;
      P_HORA_H: in_port_d = hora_h_q;
      P_DIA_F:  in_port_d = dia_fecha;
      P_MES_F:  in_port_d = mes_f_q;
      P_JAHR_F: in_port_d = jahr_f_q;
      P_SEG_T:  in_port_d = seg_timer;
      P_MIN_T:  in_port_d = min_t_q;
      P_HORA_T: in_port_d = hora_t_q;
      P_STAT:   in_port_d = {{(DATA_W-2){1'b0}}, flag_q, 1'b0};
      default:  in_port_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      in_port_q <= '0;
      min_h_q   <= '0;
      hora_h_q  <= '0;
      mes_f_q   <= '0;
      jahr_f_q  <= '0;
      min_t_q   <= '0;
      hora_t_q  <= '0;
      flag_q    <= 1'b0;
    end else begin
      in_port_q <= in_port_d;
      min_h_q   <= min_h_d;
      hora_h_q  <= hora_h_d;
      mes_f_q   <= mes_f_d;
      jahr_f_q  <= jahr_f_d;
      min_t_q   <= min_t_d;
      hora_t_q  <= hora_t_d;
      flag_q    <= flag_d;
    end
  end

  assign in_port   = in_port_q;
  assign irq_timer = flag_q;

endmodule
